dense_requant_relu: RTL
=======================

# dense_requant_relu

Downstream stage of the dense_25D layer. Consumes the per-tree 32-bit signed accumulations on `pixel_vector_out` and tracks which cycles carry valid convolution windows, skipping pipeline fill and row wrap-around positions. For each valid window it adds a per-tree bias, applies ReLU, round-shifts and saturates to 8 bits. The result is an 8-bit-per-tree pixel vector with a valid strobe, ready for the next layer's shift register.

## Interface
- `NUM_TREES`, 2: number of kernels (output channels), matching the upstream dense_25D.
- `IMG_WIDTH`, 8: input image width in pixels.
- `IMG_HEIGHT`, 8: input image height in pixels.
- `KERNEL_WIDTH`, 4: square kernel side (upstream NUM_SR_ROWS).
- `FILL_LATENCY`, 23: cycles from `start` acceptance to the first valid window on `pixel_vector_in`; must be ≥ 1.
- `SHIFT`, 4: right-shift applied after the bias add; range 0..31.

Ports (clock and reset first):
- `clock` in 1: single clock domain; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: one-cycle pulse marking the first pixel of a frame entering upstream.
- `pixel_vector_in` in 32*NUM_TREES: upstream accumulations, tree i at [32i+31:32i], two's complement.
- `bias` in 32*NUM_TREES: per-tree signed bias, same packing; held static during a frame.
- `pixel_vector_out` out 8*NUM_TREES: unsigned 8-bit result per tree, tree i at [8i+7:8i].
- `pixel_out_valid` out 1: `pixel_vector_out` holds a valid window result.
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-cycle pulse coincident with the last valid output of a frame.

## Operation
- Derived: OUT_W = IMG_WIDTH-KERNEL_WIDTH+1, OUT_H = IMG_HEIGHT-KERNEL_WIDTH+1.
- FSM states: IDLE, FILL, ROW_VALID, ROW_SKIP.
  - IDLE: wait for `start`. On `start`, load the fill counter and go to FILL.
  - FILL: count FILL_LATENCY-1 further cycles, then go to ROW_VALID.
  - ROW_VALID: assert the internal `win_valid` for OUT_W cycles.
    - After the last column, if more rows remain, go to ROW_SKIP.
    - After the last column of the last row, go to IDLE.
  - ROW_SKIP: hold for KERNEL_WIDTH-1 cycles, then go to ROW_VALID on the next row. When KERNEL_WIDTH = 1, go directly to the next ROW_VALID.
- A frame spans OUT_H*OUT_W + (OUT_H-1)*(KERNEL_WIDTH-1) cycles after fill. Defaults: 37 cycles, 25 valid windows.
- `start` is ignored outside IDLE. A new `start` in the same cycle that the FSM returns to IDLE is ignored.
- Pipeline stage 1, for each tree on `win_valid`: s = sign-extended `pixel_vector_in` + sign-extended `bias`, computed at 33 bits with no overflow.
- Pipeline stage 2:
  - If s ≤ 0, result is 0.
  - Otherwise r = (s + 2^(SHIFT-1)) >>> SHIFT, omitting the rounding term when SHIFT = 0.
  - If r > 255, result is 255; else result is r[7:0].
- Data registers update only on valid stages. `pixel_vector_out` holds its last value while `pixel_out_valid` is low.

## Timing
- `start` sampled at edge t0. The first window is sampled from `pixel_vector_in` at edge t0+FILL_LATENCY.
- Output latency is 2 cycles: window sampled at edge t gives `pixel_out_valid` high after edge t+2.
- Defaults: the first output is valid after edge t0+25; the last output and `frame_done` are valid after edge t0+61.
- `busy` goes high after edge t0 and low after the edge following the `frame_done` cycle. `frame_done` is high for exactly one cycle.
- Consecutive valid windows within a row give back-to-back `pixel_out_valid` cycles. Each skip gap produces KERNEL_WIDTH-1 low cycles.
- Reset values: `pixel_vector_out` = 0, `pixel_out_valid` = 0, `busy` = 0, `frame_done` = 0, FSM = IDLE, all counters 0.
- Reset asserted mid-frame: all outputs clear immediately without waiting for a clock. In-flight pipeline data is discarded; no `frame_done` is produced.

## Test plan
- Arithmetic, default SHIFT=4, bias 0: tree0 in 1140 -> 71; tree1 in 1732 -> 108; next window 1292/1964 -> 81/123.
- ReLU, bias and saturation: in -5 -> 0; in 100 with bias -200 -> 0; in 5000 -> 255; in 0x7FFFFFFF with bias 1 -> 255 (no wrap).
- Rounding: in 24 -> 2; in 23 -> 1; in 8 -> 1; in 7 -> 0. With SHIFT=0: in 200 -> 200, in 300 -> 255.
- Framing with defaults:
  - `start` at t0 gives exactly 25 `pixel_out_valid` cycles, in groups of 5 separated by 3-cycle gaps.
  - The first output is valid after t0+25.
  - `frame_done` coincides with the 25th valid output; `busy` falls one cycle later.
- `start` pulsed at t0+10 during a frame is ignored (still 25 outputs). A second `start` after `busy` falls runs a complete second frame.
- `reset` asserted at t0+40 mid-frame: outputs go to 0 asynchronously, no `frame_done`. A fresh `start` after release yields a full 25-output frame.

Source files
------------

// File: rtl/dense_requant_relu.sv
// dense_requant_relu
// Post-processing stage for the dense_25D layer. Tracks which upstream
// cycles carry valid convolution windows, skipping pipeline fill and row
// wrap-around positions. For each valid window it adds a per-tree bias,
// applies ReLU, rounds, shifts right and saturates to an unsigned byte.
//
// Ports:
//   clock            - single clock, rising edge
//   reset            - asynchronous active-high clear of all state
//   start            - one-cycle pulse: first pixel of a frame enters upstream
//   pixel_vector_in  - 32-bit signed accumulation per tree, tree i at [32i+31:32i]
//   bias             - 32-bit signed bias per tree, same packing, static per frame
//   pixel_vector_out - 8-bit unsigned result per tree, tree i at [8i+7:8i]
//   pixel_out_valid  - pixel_vector_out carries a window result this cycle
//   busy             - a frame is in progress (start up to the end of frame_done)
//   frame_done       - pulse coincident with the last valid output of a frame
module dense_requant_relu #(
  parameter int NUM_TREES    = 2,
  parameter int IMG_WIDTH    = 8,
  parameter int IMG_HEIGHT   = 8,
  parameter int KERNEL_WIDTH = 4,
  parameter int FILL_LATENCY = 23,
  parameter int SHIFT        = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [32*NUM_TREES-1:0]   pixel_vector_in,
  input  logic [32*NUM_TREES-1:0]   bias,
  output logic [8*NUM_TREES-1:0]    pixel_vector_out,
  output logic                      pixel_out_valid,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int OUT_W = IMG_WIDTH - KERNEL_WIDTH + 1;
  localparam int OUT_H = IMG_HEIGHT - KERNEL_WIDTH + 1;
  localparam int CNT_W = 16;

  // Down-counters are loaded with (cycles - 1) and leave their state at zero.
  localparam logic [CNT_W-1:0] FILL_LOAD = CNT_W'((FILL_LATENCY > 1) ? FILL_LATENCY - 2 : 0);
  localparam logic [CNT_W-1:0] SKIP_LOAD = CNT_W'((KERNEL_WIDTH > 1) ? KERNEL_WIDTH - 2 : 0);
  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(OUT_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(OUT_H - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Half-LSB rounding term; absent when there is no shift.
  localparam logic [33:0] ROUND = (SHIFT == 0) ? 34'd0 : (34'd1 << ((SHIFT > 0) ? (SHIFT - 1) : 0));

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_ROW_VALID,
    S_ROW_SKIP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_row;
  logic             r_busy;

  logic r_s1_valid, r_s1_last;
  logic r_s2_valid, r_s2_last;
  logic r_out_valid, r_frame_done;

  logic w_start_ok;
  logic w_win_valid;
  logic w_win_last;

  // busy stays high through the output drain, so a start is only taken
  // once the previous frame has fully left the pipeline.
  assign w_start_ok  = start && (r_state == S_IDLE) && !r_busy;
  assign w_win_valid = (r_state == S_ROW_VALID);
  assign w_win_last  = w_win_valid && (r_cnt == COL_LAST) && (r_row == ROW_LAST);

  // Window-tracking FSM; r_cnt is the fill/skip down-counter or the column index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_row   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_row <= '0;
            if (FILL_LATENCY == 1) begin
              r_state <= S_ROW_VALID;
              r_cnt   <= '0;
            end else begin
              r_state <= S_FILL;
              r_cnt   <= FILL_LOAD;
            end
          end
        end
        S_FILL: begin
          if (r_cnt == '0) r_state <= S_ROW_VALID;
          else             r_cnt   <= r_cnt - CNT_ONE;
        end
        S_ROW_VALID: begin
          if (r_cnt == COL_LAST) begin
            if (r_row == ROW_LAST) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end else begin
              r_row   <= r_row + CNT_ONE;
              r_state <= (KERNEL_WIDTH > 1) ? S_ROW_SKIP : S_ROW_VALID;
              r_cnt   <= (KERNEL_WIDTH > 1) ? SKIP_LOAD : '0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_ROW_SKIP: begin
          if (r_cnt == '0) r_state <= S_ROW_VALID;
          else             r_cnt   <= r_cnt - CNT_ONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Valid/last tags travel alongside the data through the three stages.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_last    <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_s2_last    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_s1_valid   <= w_win_valid;
      r_s1_last    <= w_win_last;
      r_s2_valid   <= r_s1_valid;
      r_s2_last    <= r_s1_valid && r_s1_last;
      r_out_valid  <= r_s2_valid;
      r_frame_done <= r_s2_valid && r_s2_last;
      if (w_start_ok)        r_busy <= 1'b1;
      else if (r_frame_done) r_busy <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TREES; gi++) begin : g_tree
      logic [31:0] w_pix;
      logic [31:0] w_bias;
      logic [32:0] r_sum;   // two's complement, 33 bits so the add cannot overflow
      logic        r_sat;
      logic [7:0]  r_lo;
      logic [7:0]  r_out;
      logic        w_nonpos;
      logic [33:0] w_rnd;
      logic [33:0] w_shr;

      assign w_pix    = pixel_vector_in[32*gi +: 32];
      assign w_bias   = bias[32*gi +: 32];
      assign w_nonpos = r_sum[32] || (r_sum == '0);
      // Only used when the sum is positive, so a logical shift is exact and
      // the 34-bit width absorbs the rounding carry even at SHIFT = 31.
      assign w_rnd    = {r_sum[32], r_sum} + ROUND;
      assign w_shr    = w_rnd >> SHIFT;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_sum <= '0;
          r_sat <= 1'b0;
          r_lo  <= '0;
          r_out <= '0;
        end else begin
          if (w_win_valid) begin
            r_sum <= {w_pix[31], w_pix} + {w_bias[31], w_bias};
          end
          if (r_s1_valid) begin
            if (w_nonpos) begin
              r_sat <= 1'b0;
              r_lo  <= '0;
            end else begin
              r_sat <= |w_shr[33:8];
              r_lo  <= w_shr[7:0];
            end
          end
          if (r_s2_valid) begin
            r_out <= r_sat ? 8'hFF : r_lo;
          end
        end
      end

      assign pixel_vector_out[8*gi +: 8] = r_out;
    end
  endgenerate

  assign pixel_out_valid = r_out_valid;
  assign frame_done      = r_frame_done;
  assign busy            = r_busy;

endmodule
